min_distortion_tracker: RTL and testbench
=========================================

Name: min_distortion_tracker

Overview:
- Downstream of the PE array in the motion estimator.
- Consumes one saturated 8-bit accumulated distortion per candidate position. Candidates arrive in raster order over the search window.
- Tracks the minimum distortion and its motion vector, and pulses done when the last candidate has been evaluated.
- Its outputs feed the motion-vector writeback logic.

Parameters:
- DIST_W, 8: width of the distortion value. Matches the PE Accumulate width; 2^DIST_W-1 is the saturated value.
- WIN_W, 16: candidate positions per search-window row.
- WIN_H, 16: candidate rows per search window.
- MV_BITS, 4: width of each motion-vector component. Requires 2^MV_BITS >= WIN_W and 2^MV_BITS >= WIN_H.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a new search; single-cycle pulse from control.
- dist_valid  input  1  distortion holds a finished candidate distortion this cycle.
- distortion  input  DIST_W  accumulated distortion from the PE array, saturated at all-ones.
- busy  output  1  high while in SEARCH.
- done  output  1  one-cycle pulse; best_* are final.
- best_dist  output  DIST_W  minimum distortion found so far.
- best_x  output  MV_BITS  column index of the best candidate.
- best_y  output  MV_BITS  row index of the best candidate.

Behaviour:
- Reset state:
  - state=IDLE, busy=0, done=0.
  - best_dist=all-ones, best_x=0, best_y=0.
  - Internal cx=0, cy=0, have_best=0.
- States:
  - IDLE -> SEARCH on start.
  - SEARCH -> DONE when the accepted candidate is at cx=WIN_W-1, cy=WIN_H-1.
  - DONE -> IDLE unconditionally after one cycle; DONE -> SEARCH if start is high.
- Output decode: busy=(state==SEARCH); done=(state==DONE), registered, so exactly one cycle wide.
- On start (any state, including mid-SEARCH):
  - Next cycle enters SEARCH with cx=cy=0, have_best=0, best_dist=all-ones, best_x=best_y=0.
  - An in-progress search is abandoned with no done pulse.
- start and dist_valid in the same cycle: start wins and the candidate is dropped.
- SEARCH, dist_valid=1: candidate (cx,cy) is accepted.
  - Replace the best when have_best==0 or distortion < best_dist (unsigned, strict): best_dist<=distortion, best_x<=cx, best_y<=cy, have_best<=1.
  - Ties keep the earlier raster position.
  - A first candidate at the saturated value is still recorded, so an all-saturated window returns (0,0).
- Counter advance on each accepted candidate:
  - cx increments.
  - At cx==WIN_W-1, cx wraps to 0 and cy increments.
  - After the final candidate, cx and cy wrap to 0.
- SEARCH, dist_valid=0: no change. Gaps of any length are legal.
- dist_valid outside SEARCH is ignored.
- Latency: best_* reflect an accepted candidate on the next rising edge. done asserts the cycle after the final candidate is accepted, with best_* already final.
- best_* are visible (intermediate) during SEARCH and hold after done until the next start or reset.
- Reset asserted mid-SEARCH returns to the reset state on that edge; no done pulse.
- No arithmetic beyond the compare and counters. The saturated value compares as an ordinary maximum.

Decomposition:
- Shared package me_pkg holds:
  - DIST_W and the DIST_MAX constant (all-ones).
  - The tracker state enum (IDLE, SEARCH, DONE).
  - Default WIN_W, WIN_H and MV_BITS, shared with the PE array control.
- Natural sub-module: mv_raster_counter. It holds cx/cy with clear, enable and a last-position flag, and is reusable by the search-address generator.
- Compare/update and FSM stay in the top module.

Test Plan:
1. Reset, then start with 256 candidates, distortion = 0x80 everywhere except 0x10 at (5,3) -> done one cycle after the 256th accept; best_dist=0x10, best_x=5, best_y=3.
2. All 256 candidates = 0xFF -> best_dist=0xFF, best=(0,0), done pulses exactly once.
3. 0x20 at (2,0) and at (7,9), all others 0x40 -> best=(2,0) (tie keeps earlier); best_dist=0x20.
4. Random 1–5 cycle gaps in dist_valid, plus dist_valid pulses in IDLE both before start and after done, minimum 0x00 at (15,15) -> best=(15,15), best_dist=0x00; the IDLE pulses change nothing; busy falls as done rises.
5. Start, feed 100 candidates with 0x01 at index 10, then start again (same cycle as a dist_valid) and feed a full window whose minimum is 0x05 at (1,1) -> no done pulse from the first search; final best=(1,1), best_dist=0x05.
6. Reset asserted after 50 candidates -> next edge: busy=0, done=0, best_dist=0xFF, best=(0,0); the following start and full window completes normally.

Source files
------------

// File: rtl/me_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : me_pkg                                                     |
// | Purpose : Shared motion-estimator constants and types. Holds the     |
// |           distortion width and its saturated value, the default      |
// |           search-window geometry shared with the PE array control,   |
// |           and the min-distortion tracker state encoding.             |
// | Ports   : none                                                       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package me_pkg;

  localparam int DIST_W  = 8;
  localparam int WIN_W   = 16;
  localparam int WIN_H   = 16;
  localparam int MV_BITS = 4;

  // Saturated distortion; compares as an ordinary maximum.
  localparam logic [DIST_W-1:0] DIST_MAX = {DIST_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } tracker_state_e;

endpackage : me_pkg
`default_nettype wire

// File: rtl/mv_raster_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mv_raster_counter                                          |
// | Purpose : Raster-order (x,y) position counter over a search window.  |
// |           x advances on each enable and wraps into y; after the last |
// |           position both wrap to zero. Clear has priority over enable.|
// | Ports   : clock, reset      - clock / sync active-high reset         |
// |           clear_i           - return to (0,0)                        |
// |           enable_i          - advance one position                   |
// |           cx_o, cy_o        - current column / row                   |
// |           last_o            - current position is the final one      |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module mv_raster_counter #(
  parameter int WIN_W   = me_pkg::WIN_W,
  parameter int WIN_H   = me_pkg::WIN_H,
  parameter int MV_BITS = me_pkg::MV_BITS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               enable_i,
  output logic [MV_BITS-1:0] cx_o,
  output logic [MV_BITS-1:0] cy_o,
  output logic               last_o
);
  import me_pkg::*;

  localparam logic [MV_BITS-1:0] X_LAST = MV_BITS'(WIN_W - 1);
  localparam logic [MV_BITS-1:0] Y_LAST = MV_BITS'(WIN_H - 1);

  logic [MV_BITS-1:0] cx_q, cx_d;
  logic [MV_BITS-1:0] cy_q, cy_d;
  logic               x_wrap;
  logic               y_wrap;

  assign x_wrap = (cx_q == X_LAST);
  assign y_wrap = (cy_q == Y_LAST);

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (clear_i) begin
      cx_d = '0;
      cy_d = '0;
    end else if (enable_i) begin
      if (x_wrap) begin
        cx_d = '0;
        cy_d = y_wrap ? '0 : cy_q + MV_BITS'(1);
      end else begin
        cx_d = cx_q + MV_BITS'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign cx_o   = cx_q;
  assign cy_o   = cy_q;
  assign last_o = x_wrap && y_wrap;

endmodule : mv_raster_counter
`default_nettype wire

// File: rtl/min_distortion_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : min_distortion_tracker                                     |
// | Purpose : Consumes one accumulated distortion per candidate position |
// |           (raster order over the search window), tracks the minimum  |
// |           and its motion vector, and pulses done once the final      |
// |           candidate has been evaluated.                              |
// | Ports   : clock, reset      - clock / sync active-high reset         |
// |           start             - begin (or restart) a search            |
// |           dist_valid        - distortion carries a candidate         |
// |           distortion        - saturated candidate distortion         |
// |           busy              - high while searching                   |
// |           done              - one-cycle pulse, best_* final          |
// |           best_dist/x/y     - running minimum and its position      |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module min_distortion_tracker #(
  parameter int DIST_W  = me_pkg::DIST_W,
  parameter int WIN_W   = me_pkg::WIN_W,
  parameter int WIN_H   = me_pkg::WIN_H,
  parameter int MV_BITS = me_pkg::MV_BITS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               dist_valid,
  input  logic [DIST_W-1:0]  distortion,
  output logic               busy,
  output logic               done,
  output logic [DIST_W-1:0]  best_dist,
  output logic [MV_BITS-1:0] best_x,
  output logic [MV_BITS-1:0] best_y
);
  import me_pkg::*;

  localparam logic [DIST_W-1:0] SAT = {DIST_W{1'b1}};

  tracker_state_e     state_q, state_d;
  logic [DIST_W-1:0]  best_dist_q, best_dist_d;
  logic [MV_BITS-1:0] best_x_q, best_x_d;
  logic [MV_BITS-1:0] best_y_q, best_y_d;
  logic               have_best_q, have_best_d;

  logic [MV_BITS-1:0] cx;
  logic [MV_BITS-1:0] cy;
  logic               at_last;
  logic               accept;
  logic               better;

  // start takes precedence over a coincident candidate, which is dropped.
  assign accept = (state_q == SEARCH) && dist_valid && !start;
  assign better = !have_best_q || (distortion < best_dist_q);

  mv_raster_counter #(
    .WIN_W   (WIN_W),
    .WIN_H   (WIN_H),
    .MV_BITS (MV_BITS)
  ) u_raster (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (start),
    .enable_i (accept),
    .cx_o     (cx),
    .cy_o     (cy),
    .last_o   (at_last)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SEARCH;
      SEARCH: begin
        if (start)                 state_d = SEARCH;
        else if (accept && at_last) state_d = DONE;
      end
      DONE:    state_d = start ? SEARCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Best-candidate update; the first accepted candidate always lands so an
  // all-saturated window still reports (0,0).
  always_comb begin
    best_dist_d = best_dist_q;
    best_x_d    = best_x_q;
    best_y_d    = best_y_q;
    have_best_d = have_best_q;
    if (start) begin
      best_dist_d = SAT;
      best_x_d    = '0;
      best_y_d    = '0;
      have_best_d = 1'b0;
    end else if (accept && better) begin
      best_dist_d = distortion;
      best_x_d    = cx;
      best_y_d    = cy;
      have_best_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      best_dist_q <= SAT;
      best_x_q    <= '0;
      best_y_q    <= '0;
      have_best_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      best_dist_q <= best_dist_d;
      best_x_q    <= best_x_d;
      best_y_q    <= best_y_d;
      have_best_q <= have_best_d;
    end
  end

  assign busy      = (state_q == SEARCH);
  assign done      = (state_q == DONE);
  assign best_dist = best_dist_q;
  assign best_x    = best_x_q;
  assign best_y    = best_y_q;

endmodule : min_distortion_tracker
`default_nettype wire

// File: tb/tb_min_distortion_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_min_distortion_tracker                                  |
// | Purpose : Directed self-checking bench for min_distortion_tracker.   |
// | Ports   : none                                                       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_min_distortion_tracker;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       dist_valid = 1'b0;
  logic [7:0] distortion = 8'h00;
  logic       busy;
  logic       done;
  logic [7:0] best_dist;
  logic [3:0] best_x;
  logic [3:0] best_y;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  always #5 clock = ~clock;

  always @(posedge clock) if (done === 1'b1) done_cnt <= done_cnt + 1;

  min_distortion_tracker u_dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .dist_valid (dist_valid),
    .distortion (distortion),
    .busy       (busy),
    .done       (done),
    .best_dist  (best_dist),
    .best_x     (best_x),
    .best_y     (best_y)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Distortion tables, one per test window.
  function automatic logic [7:0] pat(input int t, input int x, input int y);
    case (t)
      1:  return (x == 5 && y == 3) ? 8'h10 : 8'h80;
      2:  return 8'hFF;
      3:  return ((x == 2 && y == 0) || (x == 7 && y == 9)) ? 8'h20 : 8'h40;
      4:  return (x == 15 && y == 15) ? 8'h00 : 8'h90;
      50: return (x == 10 && y == 0) ? 8'h01 : 8'h80;
      5:  return (x == 1 && y == 1) ? 8'h05 : 8'h30;
      6:  return (x == 0 && y == 15) ? 8'h33 : 8'h60;
      default: return 8'h77;
    endcase
  endfunction

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Feed n candidates in raster order; optional 1..5 idle cycles before each.
  task automatic feed(input int t, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(1, 5);
        for (int k = 0; k < g; k++) step();
      end
      dist_valid = 1'b1;
      distortion = pat(t, i % 16, i / 16);
      step();
      dist_valid = 1'b0;
    end
  endtask

  // Full window with done-timing and final-result checks.
  task automatic full_search(input string tag, input int t, input bit gaps,
                             input logic [7:0] ed, input logic [3:0] ex, input logic [3:0] ey);
    int d0;
    d0 = done_cnt;
    feed(t, 255, gaps);
    check({tag, " busy before last"}, busy, 1);
    check({tag, " no early done"}, done_cnt - d0, 0);
    dist_valid = 1'b1;
    distortion = pat(t, 15, 15);
    step();
    dist_valid = 1'b0;
    check({tag, " done"}, done, 1);
    check({tag, " busy low at done"}, busy, 0);
    check({tag, " best_dist"}, best_dist, ed);
    check({tag, " best_x"}, best_x, ex);
    check({tag, " best_y"}, best_y, ey);
    step();
    check({tag, " done one cycle"}, done, 0);
    step();
    check({tag, " done pulse count"}, done_cnt - d0, 1);
    check({tag, " best_dist holds"}, best_dist, ed);
  endtask

  initial begin
    step();
    step();
    reset = 1'b0;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset best_dist", best_dist, 8'hFF);
    check("reset best_x", best_x, 0);
    check("reset best_y", best_y, 0);

    // 1: single minimum
    do_start();
    check("t1 busy after start", busy, 1);
    full_search("t1", 1, 1'b0, 8'h10, 4'd5, 4'd3);

    // 2: all saturated
    do_start();
    full_search("t2", 2, 1'b0, 8'hFF, 4'd0, 4'd0);

    // 3: tie keeps earlier position
    do_start();
    full_search("t3", 3, 1'b0, 8'h20, 4'd2, 4'd0);

    // 4: IDLE pulses ignored, gapped stream
    dist_valid = 1'b1; distortion = 8'h00;
    step(); step();
    dist_valid = 1'b0;
    check("t4 idle busy", busy, 0);
    check("t4 idle best_dist", best_dist, 8'h20);
    check("t4 idle best_x", best_x, 2);
    do_start();
    full_search("t4", 4, 1'b1, 8'h00, 4'd15, 4'd15);
    dist_valid = 1'b1; distortion = 8'h07;
    step(); step();
    dist_valid = 1'b0;
    step();
    check("t4 post busy", busy, 0);
    check("t4 post done", done, 0);
    check("t4 post best_dist", best_dist, 8'h00);
    check("t4 post best_x", best_x, 15);
    check("t4 post best_y", best_y, 15);

    // 5: restart mid-search, coincident candidate dropped
    begin
      int d0;
      d0 = done_cnt;
      do_start();
      feed(50, 100, 1'b0);
      check("t5 mid best_dist", best_dist, 8'h01);
      check("t5 mid best_x", best_x, 10);
      check("t5 mid best_y", best_y, 0);
      start = 1'b1; dist_valid = 1'b1; distortion = 8'h00;
      step();
      start = 1'b0; dist_valid = 1'b0;
      check("t5 restart busy", busy, 1);
      check("t5 restart best_dist", best_dist, 8'hFF);
      check("t5 restart best_x", best_x, 0);
      check("t5 no done on abandon", done_cnt - d0, 0);
      full_search("t5", 5, 1'b0, 8'h05, 4'd1, 4'd1);
    end

    // 6: reset mid-search
    begin
      int d0;
      d0 = done_cnt;
      do_start();
      feed(1, 50, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t6 reset busy", busy, 0);
      check("t6 reset done", done, 0);
      check("t6 reset best_dist", best_dist, 8'hFF);
      check("t6 reset best_x", best_x, 0);
      check("t6 reset best_y", best_y, 0);
      step();
      check("t6 no done after reset", done_cnt - d0, 0);
      do_start();
      full_search("t6", 6, 1'b0, 8'h33, 4'd0, 4'd15);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish before limit");
    $fatal(1, "timeout");
  end

endmodule : tb_min_distortion_tracker
`default_nettype wire
